// File: rtl/vt52_reply_tx.sv
// Host-bound byte transmitter: merges keyboard bytes with the VT52 identify reply (ESC / ID_BYTE)
// onto a single valid/ready stream, keeping each reply atomic.
module vt52_reply_tx #(
    parameter logic [7:0] ID_BYTE = 8'h4B
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] kbd_data,
    input  logic       kbd_valid,
    output logic       kbd_ready,
    input  logic       ident_req,
    output logic [7:0] uart_in_data,
    output logic       uart_in_valid,
    input  logic       uart_in_ready,
    output logic       busy
);

    typedef enum logic [2:0] {
        StIdle,
        StKbd,
        StRepEsc,
        StRepSlash,
        StRepId
    } state_e;

    state_e     state_q, state_d;
    logic       pending_q, pending_d;
    logic [7:0] data_q, data_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            pending_q <= 1'b0;
            data_q    <= 8'h00;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            data_q    <= data_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        // Requests arriving while one is already pending collapse into it.
        pending_d = pending_q | ident_req;
        unique case (state_q)
            StIdle: begin
                if (pending_q) begin
                    data_d    = 8'h1B;
                    state_d   = StRepEsc;
                    pending_d = ident_req;
                end else if (kbd_valid) begin
                    data_d  = kbd_data;
                    state_d = StKbd;
                end
            end
            StKbd: begin
                if (uart_in_ready) begin
                    state_d = StIdle;
                end
            end
            StRepEsc: begin
                if (uart_in_ready) begin
                    data_d  = 8'h2F;
                    state_d = StRepSlash;
                end
            end
            StRepSlash: begin
                if (uart_in_ready) begin
                    data_d  = ID_BYTE;
                    state_d = StRepId;
                end
            end
            StRepId: begin
                if (uart_in_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs depend on registered state only, so reset clears them asynchronously.
    assign kbd_ready     = (state_q == StIdle) && !pending_q && !reset;
    assign uart_in_valid = (state_q != StIdle);
    assign uart_in_data  = data_q;
    assign busy          = (state_q != StIdle) || pending_q;

endmodule

// File: tb/tb_vt52_reply_tx.sv
// Self-checking bench for vt52_reply_tx: scoreboard of expected UART bytes plus cycle-exact
// checks of ready/valid/busy timing around replies, backpressure, collisions and reset.
module tb_vt52_reply_tx;

    logic       clk;
    logic       reset;
    logic [7:0] kbd_data;
    logic       kbd_valid;
    logic       kbd_ready;
    logic       ident_req;
    logic [7:0] uart_in_data;
    logic       uart_in_valid;
    logic       uart_in_ready;
    logic       busy;

    int         n_tests;
    int         n_fail;
    logic [7:0] sb_q[$];
    logic       prev_stall;
    logic [7:0] prev_data;

    vt52_reply_tx #(
        .ID_BYTE(8'h4B)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .kbd_data     (kbd_data),
        .kbd_valid    (kbd_valid),
        .kbd_ready    (kbd_ready),
        .ident_req    (ident_req),
        .uart_in_data (uart_in_data),
        .uart_in_valid(uart_in_valid),
        .uart_in_ready(uart_in_ready),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_reply();
        sb_q.push_back(8'h1B);
        sb_q.push_back(8'h2F);
        sb_q.push_back(8'h4B);
    endtask

    // Monitor: every UART handshake pops the scoreboard; stalled bytes must be held.
    always @(negedge clk) begin
        if (!reset) begin
            if (prev_stall) begin
                check("hold_valid", {31'd0, uart_in_valid}, 32'd1);
                check("hold_data", {24'd0, uart_in_data}, {24'd0, prev_data});
            end
            if (uart_in_valid && uart_in_ready) begin
                if (sb_q.size() == 0) begin
                    check("sb_extra_byte", {24'd0, uart_in_data}, 32'hFFFF_FFFF);
                end else begin
                    check("sb_byte", {24'd0, uart_in_data}, {24'd0, sb_q.pop_front()});
                end
            end
            prev_stall = uart_in_valid && !uart_in_ready;
            prev_data  = uart_in_data;
        end else begin
            prev_stall = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rep [3];
        rep[0] = 8'h1B;
        rep[1] = 8'h2F;
        rep[2] = 8'h4B;
        n_tests       = 0;
        n_fail        = 0;
        prev_stall    = 1'b0;
        prev_data     = 8'h00;
        reset         = 1'b1;
        kbd_data      = 8'h00;
        kbd_valid     = 1'b0;
        ident_req     = 1'b0;
        uart_in_ready = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_kbd_ready", {31'd0, kbd_ready}, 32'd0);
        check("rst_valid", {31'd0, uart_in_valid}, 32'd0);
        reset = 1'b0;
        tick();
        check("rel_kbd_ready", {31'd0, kbd_ready}, 32'd1);
        check("rel_valid", {31'd0, uart_in_valid}, 32'd0);
        check("rel_data", {24'd0, uart_in_data}, 32'h00);
        check("rel_busy", {31'd0, busy}, 32'd0);

        // Keyboard path: back-to-back bytes, one accept every 2 cycles
        uart_in_ready = 1'b1;
        kbd_data      = 8'h41;
        kbd_valid     = 1'b1;
        check("kbd_accept0", {31'd0, kbd_ready}, 32'd1);
        sb_q.push_back(8'h41);
        tick();
        kbd_data = 8'h42;
        check("kbd_valid1", {31'd0, uart_in_valid}, 32'd1);
        check("kbd_data1", {24'd0, uart_in_data}, 32'h41);
        check("kbd_ready_n1", {31'd0, kbd_ready}, 32'd0);
        check("kbd_busy1", {31'd0, busy}, 32'd1);
        tick();
        check("kbd_accept2", {31'd0, kbd_ready}, 32'd1);
        check("kbd_valid_once", {31'd0, uart_in_valid}, 32'd0);
        sb_q.push_back(8'h42);
        tick();
        kbd_valid = 1'b0;
        check("kbd_data2", {24'd0, uart_in_data}, 32'h42);
        tick();
        check("kbd_idle_valid", {31'd0, uart_in_valid}, 32'd0);
        check("kbd_idle_busy", {31'd0, busy}, 32'd0);

        // Identify with ready held high
        ident_req = 1'b1;
        push_reply();
        tick();
        ident_req = 1'b0;
        check("id_n1_busy", {31'd0, busy}, 32'd1);
        check("id_n1_valid", {31'd0, uart_in_valid}, 32'd0);
        check("id_n1_kbd_ready", {31'd0, kbd_ready}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("id_valid", {31'd0, uart_in_valid}, 32'd1);
            check("id_data", {24'd0, uart_in_data}, {24'd0, rep[i]});
            check("id_kbd_ready", {31'd0, kbd_ready}, 32'd0);
        end
        tick();
        check("id_end_valid", {31'd0, uart_in_valid}, 32'd0);
        check("id_end_kbd_ready", {31'd0, kbd_ready}, 32'd1);
        check("id_end_busy", {31'd0, busy}, 32'd0);

        // Backpressure during the '/' byte
        ident_req = 1'b1;
        push_reply();
        tick();
        ident_req = 1'b0;
        tick();
        check("bp_esc", {24'd0, uart_in_data}, 32'h1B);
        tick();
        uart_in_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("bp_hold_valid", {31'd0, uart_in_valid}, 32'd1);
            check("bp_hold_data", {24'd0, uart_in_data}, 32'h2F);
            tick();
        end
        uart_in_ready = 1'b1;
        check("bp_last_data", {24'd0, uart_in_data}, 32'h2F);
        tick();
        check("bp_id_data", {24'd0, uart_in_data}, 32'h4B);
        check("bp_id_valid", {31'd0, uart_in_valid}, 32'd1);
        tick();
        check("bp_end_valid", {31'd0, uart_in_valid}, 32'd0);

        // Collision: keyboard byte and ident_req together, then a second request mid-reply
        kbd_data  = 8'h62;
        kbd_valid = 1'b1;
        ident_req = 1'b1;
        sb_q.push_back(8'h62);
        push_reply();
        tick();
        kbd_valid = 1'b0;
        ident_req = 1'b0;
        check("col_kbd_data", {24'd0, uart_in_data}, 32'h62);
        check("col_kbd_valid", {31'd0, uart_in_valid}, 32'd1);
        tick();
        check("col_gap_valid", {31'd0, uart_in_valid}, 32'd0);
        check("col_gap_kbd_ready", {31'd0, kbd_ready}, 32'd0);
        tick();
        check("col_esc", {24'd0, uart_in_data}, 32'h1B);
        ident_req = 1'b1;
        push_reply();
        tick();
        ident_req = 1'b0;
        check("col_slash", {24'd0, uart_in_data}, 32'h2F);
        tick();
        check("col_id", {24'd0, uart_in_data}, 32'h4B);
        tick();
        check("col_idle_gap", {31'd0, uart_in_valid}, 32'd0);
        check("col_idle_busy", {31'd0, busy}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("col_rep2_data", {24'd0, uart_in_data}, {24'd0, rep[i]});
        end
        tick();
        check("col_end_valid", {31'd0, uart_in_valid}, 32'd0);
        tick();
        check("col_no_third", {31'd0, uart_in_valid}, 32'd0);
        check("col_end_busy", {31'd0, busy}, 32'd0);

        // Reset in REP_SLASH abandons the reply
        ident_req = 1'b1;
        sb_q.push_back(8'h1B);
        tick();
        ident_req = 1'b0;
        tick();
        tick();
        uart_in_ready = 1'b0;
        check("rs_slash", {24'd0, uart_in_data}, 32'h2F);
        reset = 1'b1;
        #1;
        check("rs_async_valid", {31'd0, uart_in_valid}, 32'd0);
        check("rs_async_kbd_ready", {31'd0, kbd_ready}, 32'd0);
        tick();
        tick();
        reset         = 1'b0;
        uart_in_ready = 1'b1;
        tick();
        check("rs_idle_busy", {31'd0, busy}, 32'd0);
        check("rs_idle_kbd_ready", {31'd0, kbd_ready}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            check("rs_no_residual", {31'd0, uart_in_valid}, 32'd0);
            tick();
        end

        check("sb_empty", sb_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
